// File: rtl/usb_reg_master.sv
// Bus initiator for the USB-chip parallel register interface. It turns command and
// stream handshakes into timed cen/rdn/wrn strobes for single bytes or same-address bursts.
//
// state   | meaning
// IDLE    | bus released, waiting for a command
// FETCH   | write burst, waiting for the next write byte
// SETUP   | cen low, address/data stable before the strobe
// STROBE  | rdn or wrn held low
// RECOVER | strobes high, slave updates its byte counter
module usb_reg_master #(
  parameter int pLEN_WIDTH      = 3,
  parameter int pSETUP_CYCLES   = 2,
  parameter int pSTROBE_CYCLES  = 4,
  parameter int pRECOVER_CYCLES = 3
) (
  input  logic                  clk_usb,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [7:0]            cmd_addr,
  input  logic [pLEN_WIDTH-1:0] cmd_len,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            usb_addr,
  output logic [7:0]            usb_dout,
  input  logic [7:0]            usb_din,
  output logic                  usb_drive,
  output logic                  usb_rdn,
  output logic                  usb_wrn,
  output logic                  usb_cen
);

  localparam logic [7:0] LP_SETUP   = 8'(pSETUP_CYCLES - 1);
  localparam logic [7:0] LP_STROBE  = 8'(pSTROBE_CYCLES - 1);
  localparam logic [7:0] LP_RECOVER = 8'(pRECOVER_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_STROBE,
    ST_RECOVER
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic [7:0]            r_addr;
  logic [7:0]            r_dout;
  logic [7:0]            r_rd_data;
  logic                  r_rd_valid;
  logic [pLEN_WIDTH-1:0] r_remaining;
  logic [7:0]            r_cnt;
  logic                  r_cen;
  logic                  r_rdn;
  logic                  r_wrn;
  logic                  r_drive;
  logic                  r_done;

  logic w_rd_hs;
  logic w_rd_pending;

  assign w_rd_hs      = r_rd_valid & rd_ready;
  assign w_rd_pending = r_rd_valid & ~rd_ready;

  always_ff @(posedge clk_usb) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_addr      <= 8'd0;
      r_dout      <= 8'd0;
      r_rd_data   <= 8'd0;
      r_rd_valid  <= 1'b0;
      r_remaining <= '0;
      r_cnt       <= 8'd0;
      r_cen       <= 1'b1;
      r_rdn       <= 1'b1;
      r_wrn       <= 1'b1;
      r_drive     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_rd_hs) r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_addr;
            r_write     <= cmd_write;
            r_remaining <= cmd_len;
            if (cmd_write) begin
              r_state <= ST_FETCH;
            end else begin
              r_state <= ST_SETUP;
              r_cen   <= 1'b0;
              r_drive <= 1'b0;
              r_cnt   <= LP_SETUP;
            end
          end
        end
        ST_FETCH: begin
          if (wr_valid) begin
            r_dout  <= wr_data;
            r_drive <= 1'b1;
            r_cen   <= 1'b0;
            r_cnt   <= LP_SETUP;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_cnt   <= LP_STROBE;
            r_state <= ST_STROBE;
            if (r_write) r_wrn <= 1'b0;
            else         r_rdn <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_STROBE: begin
          if (r_cnt == 8'd0) begin
            r_rdn   <= 1'b1;
            r_wrn   <= 1'b1;
            r_cnt   <= LP_RECOVER;
            r_state <= ST_RECOVER;
            if (!r_write) begin
              r_rd_data  <= usb_din;
              r_rd_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_RECOVER: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (!w_rd_pending) begin
            // a read byte consumed in this very cycle lets the burst continue at once
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - pLEN_WIDTH'(1);
              if (r_write) begin
                r_state <= ST_FETCH;
              end else begin
                r_cnt   <= LP_SETUP;
                r_state <= ST_SETUP;
              end
            end else begin
              r_cen   <= 1'b1;
              r_drive <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign wr_ready  = (r_state == ST_FETCH);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign usb_addr  = r_addr;
  assign usb_dout  = r_dout;
  assign usb_drive = r_drive;
  assign usb_rdn   = r_rdn;
  assign usb_wrn   = r_wrn;
  assign usb_cen   = r_cen;

endmodule

// File: tb/tb_usb_reg_master.sv
// Directed bench for usb_reg_master with a behavioural register slave whose read data
// is 0x40 plus a byte counter that resets whenever cen goes high.
module tb_usb_reg_master;

  logic       clk_usb = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'd0;
  logic [2:0] cmd_len = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] usb_addr;
  logic [7:0] usb_dout;
  logic [7:0] usb_din = 8'h40;
  logic       usb_drive;
  logic       usb_rdn;
  logic       usb_wrn;
  logic       usb_cen;

  usb_reg_master dut (
    .clk_usb(clk_usb), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .usb_addr(usb_addr), .usb_dout(usb_dout), .usb_din(usb_din),
    .usb_drive(usb_drive), .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen)
  );

  always #5 clk_usb = ~clk_usb;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // bus monitor and slave model, sampled on the falling edge
  logic       p_wrn = 1'b1, p_rdn = 1'b1, p_cen = 1'b1, rd_burst = 1'b0;
  logic [7:0] p_addr = 8'd0, slv_wdata = 8'd0;
  int wrn_run = 0, last_wrn_len = 0, n_rdn = 0, n_done = 0, n_accept = 0;
  int slv_writes = 0, bytecnt = 0, last_bytecnt = 0;
  int err_both = 0, err_drive = 0, err_addr = 0, err_strobe = 0, hold_err = 0, gap_err = 0;

  always @(negedge clk_usb) begin
    if (!usb_wrn && !usb_rdn) err_both++;
    if (usb_cen && (!usb_wrn || !usb_rdn)) err_strobe++;
    if (!usb_rdn) rd_burst = 1'b1;
    if (usb_drive && (rd_burst || !busy)) err_drive++;
    if (!usb_cen && !p_cen && usb_addr !== p_addr) err_addr++;
    if (!usb_wrn) wrn_run++;
    else if (!p_wrn) begin
      last_wrn_len = wrn_run;
      wrn_run = 0;
      if (!usb_cen) begin
        slv_writes++;
        slv_wdata = usb_dout;
        bytecnt++;
      end
    end
    if (usb_rdn && !p_rdn) begin
      n_rdn++;
      bytecnt++;
    end
    if (usb_cen && !p_cen) begin
      last_bytecnt = bytecnt;
      bytecnt = 0;
      rd_burst = 1'b0;
    end
    if (done) n_done++;
    usb_din = 8'h40 + 8'(bytecnt);
    p_wrn = usb_wrn; p_rdn = usb_rdn; p_cen = usb_cen; p_addr = usb_addr;
  end

  always @(posedge clk_usb) if (cmd_valid && cmd_ready) n_accept++;

  task automatic tick();
    @(negedge clk_usb);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [2:0] l);
    int n;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("cmd_ready_timeout", n, 0);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input int gap);
    int n;
    n = 0;
    while (!wr_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("wr_ready_timeout", n, 0);
    repeat (gap) begin
      tick();
      if (!(usb_cen == 1'b0 && usb_wrn && usb_rdn && wr_ready)) gap_err++;
    end
    wr_data = d; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input logic chk_wr, input logic [7:0] exp_dout);
    int n;
    n = 0;
    while (!done && n < 200) begin
      if (chk_wr && !usb_cen && (!usb_drive || usb_dout !== exp_dout)) hold_err++;
      tick(); n++;
    end
    if (n >= 200) chk("done_timeout", n, 0);
  endtask

  task automatic get_byte(input logic [7:0] exp, input int stall);
    int n, r0, k;
    logic [7:0] d;
    logic stable;
    n = 0;
    while (!rd_valid && n < 100) begin tick(); n++; end
    if (n >= 100) chk("rd_valid_timeout", n, 0);
    chk("rd_byte", rd_data, exp);
    if (stall > 0) begin
      r0 = n_rdn; d = rd_data; stable = 1'b1;
      repeat (stall) begin
        tick();
        if (rd_data !== d || !rd_valid || !usb_rdn) stable = 1'b0;
      end
      chk("stall_stable", stable, 1);
      chk("stall_no_strobe", n_rdn - r0, 0);
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      k = 1;
      while (usb_rdn && k < 10) begin tick(); k++; end
      chk("stall_resume", k, 3);
    end else begin
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
  endtask

  initial begin
    int d0, w0, r0, a0, n;
    int t_cen, t_r0, t_r1, t_rv, t_dn;
    logic [7:0] lat_data;

    repeat (3) tick();
    chk("rst_bus", {usb_cen, usb_rdn, usb_wrn, usb_drive}, 4'b1110);
    chk("rst_data", {usb_addr, usb_dout, rd_data}, 24'h0);
    chk("rst_flags", {rd_valid, done, busy, cmd_ready, wr_ready}, 5'b00010);
    reset_n = 1'b1;
    tick();

    // single write 0xA5 to 0x12
    d0 = n_done; w0 = slv_writes;
    send_cmd(1'b1, 8'h12, 3'd0);
    write_byte(8'hA5, 0);
    wait_done(1'b1, 8'hA5);
    repeat (3) tick();
    chk("wr1_wrn_len", last_wrn_len, 4);
    chk("wr1_slave_writes", slv_writes - w0, 1);
    chk("wr1_slave_data", slv_wdata, 8'hA5);
    chk("wr1_hold", hold_err, 0);
    chk("wr1_done_pulses", n_done - d0, 1);

    // single-byte read latency with rd_ready held high
    rd_ready = 1'b1;
    cmd_write = 1'b0; cmd_addr = 8'h33; cmd_len = 3'd0; cmd_valid = 1'b1;
    t_cen = -1; t_r0 = -1; t_r1 = -1; t_rv = -1; t_dn = -1; lat_data = 8'h00;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 1) cmd_valid = 1'b0;
      if (!usb_cen && t_cen < 0) t_cen = t;
      if (!usb_rdn) begin
        if (t_r0 < 0) t_r0 = t;
        t_r1 = t;
      end
      if (rd_valid && t_rv < 0) begin t_rv = t; lat_data = rd_data; end
      if (done && t_dn < 0) t_dn = t;
    end
    rd_ready = 1'b0;
    chk("lat_cen", t_cen, 1);
    chk("lat_rdn_first", t_r0, 3);
    chk("lat_rdn_last", t_r1, 6);
    chk("lat_rd_valid", t_rv, 7);
    chk("lat_done", t_dn, 10);
    chk("lat_data", lat_data, 8'h40);

    // read burst of 4 at 0x20, stalling after byte 0
    r0 = n_rdn;
    send_cmd(1'b0, 8'h20, 3'd3);
    get_byte(8'h40, 10);
    get_byte(8'h41, 0);
    get_byte(8'h42, 0);
    get_byte(8'h43, 0);
    wait_done(1'b0, 8'h00);
    tick();
    chk("rdb_rdn_pulses", n_rdn - r0, 4);
    chk("rdb_drive", err_drive, 0);
    chk("rdb_addr_const", err_addr, 0);

    // write burst of 3 with an 8-cycle gap before byte 2
    w0 = slv_writes;
    send_cmd(1'b1, 8'h05, 3'd2);
    write_byte(8'h11, 0);
    write_byte(8'h22, 8);
    write_byte(8'h33, 0);
    wait_done(1'b0, 8'h00);
    tick();
    chk("wrb_gap", gap_err, 0);
    chk("wrb_bytecnt", last_bytecnt, 3);
    chk("wrb_writes", slv_writes - w0, 3);
    chk("wrb_last_data", slv_wdata, 8'h33);

    // reset during the write strobe
    send_cmd(1'b1, 8'h44, 3'd1);
    write_byte(8'h99, 0);
    n = 0;
    while (usb_wrn && n < 50) begin tick(); n++; end
    chk("rst_mid_reach_strobe", usb_wrn, 0);
    d0 = n_done;
    reset_n = 1'b0;
    tick();
    chk("rst_mid_bus", {usb_cen, usb_wrn, usb_drive, busy}, 4'b1100);
    reset_n = 1'b1;
    tick();
    chk("rst_mid_ready", cmd_ready, 1);
    repeat (20) tick();
    chk("rst_mid_no_done", n_done - d0, 0);

    // cmd_valid held high across a whole burst
    rd_ready = 1'b1;
    a0 = n_accept;
    cmd_write = 1'b0; cmd_addr = 8'h50; cmd_len = 3'd0; cmd_valid = 1'b1;
    tick();
    wait_done(1'b0, 8'h00);
    chk("busy_accepts_before_done", n_accept - a0, 1);
    chk("busy_ready_at_done", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("busy_accepts_after_done", n_accept - a0, 2);
    chk("busy_second_cmd", busy, 1);
    wait_done(1'b0, 8'h00);
    rd_ready = 1'b0;
    repeat (3) tick();

    chk("never_both_strobes", err_both, 0);
    chk("no_strobe_outside_cen", err_strobe, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
